grey_counter: RTL and testbench
===============================

GREY_COUNTER -- requirements
Module: grey_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (minimum 2).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the binary count loaded at reset and by clear.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous return to RESET_VALUE.
REQ-006 load  input  1  synchronous load of load_value.
REQ-007 load_value  input  WIDTH  binary value to load.
REQ-008 increment  input  1  count up by one.
REQ-009 decrement  input  1  count down by one.
REQ-010 binary  output  WIDTH  current count, binary.
REQ-011 grey  output  WIDTH  current count, Grey-coded (binary ^ binary>>1).
REQ-012 wrap  output  1  one-cycle pulse marking a modular wrap.

Function
REQ-013 Each cycle, the next binary value SHALL be selected by priority: clear, then load, then increment XOR decrement, then hold.
REQ-014 When increment and decrement are both high, the count SHALL hold unless clear or load is active.
REQ-015 Increment SHALL wrap 2^WIDTH-1 -> 0, and decrement SHALL wrap 0 -> 2^WIDTH-1, modulo 2^WIDTH with no saturation.
REQ-016 Latency SHALL be one cycle: binary, grey and wrap reflect the inputs sampled at the previous rising edge.
REQ-017 grey SHALL be driven directly from a flop register with no combinational logic between flop and port, so it is safe to sample from another clock domain.
REQ-018 The grey register SHALL be loaded with the Grey encoding of the next binary value, computed before the register.
REQ-019 grey SHALL equal the Grey encoding of binary on every cycle.
REQ-020 Consecutive grey values produced by increment or decrement SHALL differ in exactly one bit, including across a wrap.
REQ-021 wrap SHALL be 1 for exactly the cycle after an increment from 2^WIDTH-1 or a decrement from 0, and 0 otherwise.
REQ-022 wrap SHALL be 0 after clear or load, even if the new value is 0 or 2^WIDTH-1.
REQ-023 A load or clear SHALL be allowed to change grey by more than one bit; no single-bit guarantee applies to it.

Reset
REQ-024 While resetn is low, the outputs SHALL be binary=RESET_VALUE, grey=Grey(RESET_VALUE) and wrap=0, asynchronously.
REQ-025 Reset asserted mid-count SHALL discard any pending operation.
REQ-026 Counting SHALL resume on the first rising edge after resetn deasserts.

Structure
REQ-027 No shared package SHALL be created; WIDTH and RESET_VALUE SHALL be module parameters only.
REQ-028 The next-value Grey encoding SHALL use one instance of the existing binary_to_grey module, at WIDTH.
REQ-029 The block SHALL contain three registers (binary, grey, wrap) and the next-state selection logic.

Verification (WIDTH=4, RESET_VALUE=0)
REQ-030 Reset: hold resetn low -> binary=0000, grey=0000, wrap=0; assert resetn low mid-count at binary=0101 -> outputs return to 0 without a clock edge.
REQ-031 Full up-count: increment=1 for 16 cycles from 0 -> grey steps 0000,0001,0011,0010,0110,...,1000,0000, each step a one-bit change; wrap=1 only in the cycle binary returns to 0000.
REQ-032 Down wrap: decrement=1 at 0 -> next cycle binary=1111, grey=1000, wrap=1; one further decrement -> binary=1110, grey=1001, wrap=0.
REQ-033 Priority: load=1 with load_value=1010 and increment=1 -> binary=1010, grey=1111; clear=1 with load=1 -> binary=0000; a load of 1111 -> wrap=0.
REQ-034 Hold: increment=1 and decrement=1 at binary=0111 -> binary stays 0111, grey stays 0100, wrap=0.
REQ-035 Random: 1000 cycles of random clear, load, increment and decrement against a reference model -> binary, grey and wrap match every cycle, and grey equals binary^(binary>>1).

Source files
------------

// File: rtl/binary_to_grey.sv
// Combinational binary-to-Grey encoder; each Grey bit is the XOR of a binary bit
// and its more significant neighbour.
module binary_to_grey #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] grey
);

    assign grey = binary ^ (binary >> 1);

endmodule

// File: rtl/grey_counter.sv
// Up/down modular counter with a registered binary count, a registered Grey copy
// and a one-cycle wrap pulse.
module grey_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] grey,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] RESET_GREY = RESET_BIN ^ (RESET_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_BIN    = '1;

    logic [WIDTH-1:0] binary_reg;
    logic [WIDTH-1:0] binary_next;
    logic [WIDTH-1:0] grey_reg;
    logic [WIDTH-1:0] grey_next;
    logic             wrap_reg;
    logic             wrap_next;

    // Opposing increment and decrement cancel and fall through to hold.
    always_comb begin
        binary_next = binary_reg;
        wrap_next   = 1'b0;
        if (clear) begin
            binary_next = RESET_BIN;
        end else if (load) begin
            binary_next = load_value;
        end else if (increment && !decrement) begin
            binary_next = binary_reg + WIDTH'(1);
            wrap_next   = (binary_reg == MAX_BIN);
        end else if (decrement && !increment) begin
            binary_next = binary_reg - WIDTH'(1);
            wrap_next   = (binary_reg == '0);
        end
    end

    // Encoding the next value keeps the grey port a bare flop output.
    binary_to_grey #(
        .WIDTH (WIDTH)
    ) u_binary_to_grey (
        .binary (binary_next),
        .grey   (grey_next)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            binary_reg <= RESET_BIN;
            grey_reg   <= RESET_GREY;
            wrap_reg   <= 1'b0;
        end else begin
            binary_reg <= binary_next;
            grey_reg   <= grey_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign binary = binary_reg;
    assign grey   = grey_reg;
    assign wrap   = wrap_reg;

endmodule

// File: tb/tb_grey_counter.sv
// Self-checking bench for grey_counter at WIDTH=4, RESET_VALUE=0, using a modular
// arithmetic reference model.
module tb_grey_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clock = 1'b0;
    logic         resetn;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         increment;
    logic         decrement;
    logic [W-1:0] binary;
    logic [W-1:0] grey;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    int exp_bin  = 0;
    bit exp_wrap = 1'b0;

    grey_counter #(
        .WIDTH       (W),
        .RESET_VALUE (0)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .increment  (increment),
        .decrement  (decrement),
        .binary     (binary),
        .grey       (grey),
        .wrap       (wrap)
    );

    always #5 clock = ~clock;

    function automatic int grey_of(input int v);
        return v ^ (v / 2);
    endfunction

    // Reference model: priority clear > load > single-direction count > hold.
    task automatic model_step(input bit c, input bit l, input int lv, input bit inc, input bit dec);
        if (c) begin
            exp_bin  = 0;
            exp_wrap = 1'b0;
        end else if (l) begin
            exp_bin  = lv;
            exp_wrap = 1'b0;
        end else if (inc && !dec) begin
            exp_wrap = (exp_bin == MOD - 1);
            exp_bin  = (exp_bin + 1) % MOD;
        end else if (dec && !inc) begin
            exp_wrap = (exp_bin == 0);
            exp_bin  = (exp_bin + MOD - 1) % MOD;
        end else begin
            exp_wrap = 1'b0;
        end
    endtask

    task automatic apply(input bit c, input bit l, input int lv, input bit inc, input bit dec);
        @(negedge clock);
        clear      = c;
        load       = l;
        load_value = W'(lv);
        increment  = inc;
        decrement  = dec;
        @(posedge clock);
        #1;
        model_step(c, l, lv, inc, dec);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear = 0; load = 0; load_value = '0; increment = 1; decrement = 0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (binary !== 4'b0000 || grey !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got bin=%b grey=%b wrap=%b want 0000 0000 0", binary, grey, wrap);
        end
        @(negedge clock);
        resetn    = 1'b1;
        increment = 1'b0;
        exp_bin   = 0;
        exp_wrap  = 1'b0;
        apply(0, 0, 0, 1, 0);
        checks++;
        if (binary !== 4'b0001 || grey !== 4'b0001) begin
            errors++;
            $display("FAIL reset_resume: got bin=%b grey=%b want 0001 0001", binary, grey);
        end
        $display("test_reset done");
    endtask

    task automatic test_up_count();
        int table_g[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        logic [W-1:0] prev;
        apply(1, 0, 0, 0, 0);
        prev = grey;
        for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 0, 1, 0);
            checks++;
            if (int'(grey) !== table_g[i % 16] || int'(binary) !== i % 16 ||
                wrap !== (i == 16) || $countones(grey ^ prev) != 1) begin
                errors++;
                $display("FAIL up_count[%0d]: got bin=%b grey=%b wrap=%b want bin=%0d grey=%0d wrap=%0d one-bit step",
                         i, binary, grey, wrap, i % 16, table_g[i % 16], (i == 16));
            end
            prev = grey;
        end
        $display("test_up_count done");
    endtask

    task automatic test_down_wrap();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1);
        checks++;
        if (binary !== 4'b1111 || grey !== 4'b1000 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: got bin=%b grey=%b wrap=%b want 1111 1000 1", binary, grey, wrap);
        end
        apply(0, 0, 0, 0, 1);
        checks++;
        if (binary !== 4'b1110 || grey !== 4'b1001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_after_wrap: got bin=%b grey=%b wrap=%b want 1110 1001 0", binary, grey, wrap);
        end
        $display("test_down_wrap done");
    endtask

    task automatic test_priority();
        apply(0, 1, 'b1010, 1, 0);
        checks++;
        if (binary !== 4'b1010 || grey !== 4'b1111 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_over_inc: got bin=%b grey=%b wrap=%b want 1010 1111 0", binary, grey, wrap);
        end
        apply(1, 1, 'b0110, 0, 1);
        checks++;
        if (binary !== 4'b0000 || grey !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clear_over_load: got bin=%b grey=%b wrap=%b want 0000 0000 0", binary, grey, wrap);
        end
        apply(0, 1, 'b1111, 0, 0);
        checks++;
        if (binary !== 4'b1111 || grey !== 4'b1000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_max_nowrap: got bin=%b grey=%b wrap=%b want 1111 1000 0", binary, grey, wrap);
        end
        apply(1, 0, 0, 1, 0);
        checks++;
        if (binary !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clear_from_max_nowrap: got bin=%b wrap=%b want 0000 0", binary, wrap);
        end
        $display("test_priority done");
    endtask

    task automatic test_hold();
        apply(0, 1, 'b0111, 0, 0);
        apply(0, 0, 0, 1, 1);
        checks++;
        if (binary !== 4'b0111 || grey !== 4'b0100 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL hold_both: got bin=%b grey=%b wrap=%b want 0111 0100 0", binary, grey, wrap);
        end
        apply(0, 1, 'b1111, 0, 0);
        apply(0, 0, 0, 1, 1);
        checks++;
        if (binary !== 4'b1111 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL hold_at_max: got bin=%b wrap=%b want 1111 0", binary, wrap);
        end
        $display("test_hold done");
    endtask

    task automatic test_async_reset();
        apply(0, 1, 'b0101, 0, 0);
        @(negedge clock);
        clear = 0; load = 0; increment = 1; decrement = 0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (binary !== 4'b0000 || grey !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got bin=%b grey=%b wrap=%b want 0000 0000 0", binary, grey, wrap);
        end
        @(posedge clock);
        #1;
        checks++;
        if (binary !== 4'b0000 || grey !== 4'b0000) begin
            errors++;
            $display("FAIL reset_discard: got bin=%b grey=%b want 0000 0000", binary, grey);
        end
        @(negedge clock);
        resetn    = 1'b1;
        increment = 1'b0;
        exp_bin   = 0;
        exp_wrap  = 1'b0;
        apply(0, 0, 0, 1, 0);
        checks++;
        if (binary !== 4'b0001 || grey !== 4'b0001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL resume_after_reset: got bin=%b grey=%b wrap=%b want 0001 0001 0", binary, grey, wrap);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        int bad = 0;
        logic [W-1:0] prev;
        bit c, l, inc, dec;
        int lv;
        prev = grey;
        for (int i = 0; i < 1000; i++) begin
            c   = ($urandom_range(0, 19) == 0);
            l   = ($urandom_range(0, 9) == 0);
            lv  = int'($urandom_range(0, MOD - 1));
            inc = $urandom_range(0, 1) == 1;
            dec = ($urandom_range(0, 2) == 0);
            apply(c, l, lv, inc, dec);
            checks++;
            if (int'(binary) !== exp_bin || int'(grey) !== grey_of(exp_bin) ||
                wrap !== exp_wrap || grey !== (binary ^ (binary >> 1)) ||
                (!c && !l && (inc ^ dec) && $countones(grey ^ prev) != 1)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got bin=%0d grey=%0d wrap=%0d want bin=%0d grey=%0d wrap=%0d",
                             i, binary, grey, wrap, exp_bin, grey_of(exp_bin), exp_wrap);
            end
            prev = grey;
        end
        $display("test_random done: 1000 cycles, %0d bad", bad);
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_priority();
        test_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
